pic_host_sequencer: RTL and testbench

CPU-side bus initiator for the 8259-compatible PIC. Drives the PIC's write port and the INTA line. On request it issues the full ICW1–ICW4 initialization sequence and an initial OCW1, then accepts single OCW writes from a command port. It answers a raised INT with the two-pulse interrupt-acknowledge cycle and returns the captured vector byte.

---
 rtl/pic_host_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_pic_host_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_host_sequencer.sv
// pic_host_sequencer: CPU-side initiator for an 8259-style PIC.
// Runs the ICW/OCW init, single OCW writes and the two-pulse INTA cycle.
module pic_host_sequencer #(
  parameter int WR_PULSE   = 2,
  parameter int INTA_PULSE = 2,
  parameter int INTA_GAP   = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic [7:0] init_mask,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in,
  input  logic       pic_int,
  output logic       inta_n,
  input  logic       ack_en,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  output logic       init_done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_INTA1  = 3'd4;
  localparam logic [2:0] S_GAP    = 3'd5;
  localparam logic [2:0] S_INTA2  = 3'd6;
  localparam logic [2:0] S_VEC    = 3'd7;

  localparam logic [7:0] WR_LAST  = 8'(WR_PULSE - 1);
  localparam logic [7:0] IA_LAST  = 8'(INTA_PULSE - 1);
  localparam logic [7:0] GAP_LAST = 8'(INTA_GAP - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] step_q, step_d;
  logic [2:0] step_nx;
  logic       act_q, act_d;
  logic       done_q, done_d;
  logic       a0_q, a0_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] w1_q, w2_q, w3_q, w4_q, wm_q;
  logic [7:0] nx_word;
  logic       sync1_q, sync2_q;
  logic       ack_go;
  logic       cs_n_q, wr_n_q, oe_q;
  logic       inta_n_q, vv_q, busy_q;

  // Step 0..4 = ICW1, ICW2, ICW3, ICW4, OCW1; 5 means finished.
  always_comb begin
    step_nx = step_q + 3'd1;
    if (step_nx == 3'd2 && w1_q[1]) step_nx = 3'd3;
    if (step_nx == 3'd3 && !w1_q[0]) step_nx = 3'd4;
  end

  always_comb begin
    case (step_nx)
      3'd1:    nx_word = w2_q;
      3'd2:    nx_word = w3_q;
      3'd3:    nx_word = w4_q;
      default: nx_word = wm_q;
    endcase
  end

  assign ack_go = sync2_q & ack_en & done_q;

  assign cmd_ready = (state_q == S_IDLE) & done_q
                   & ~ack_go & ~init_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    act_d   = act_q;
    done_d  = done_q;
    a0_d    = a0_q;
    dout_d  = dout_q;
    vec_d   = vec_q;
    case (state_q)
      S_IDLE: begin
        priority case (1'b1)
          init_start: begin
            done_d  = 1'b0;
            act_d   = 1'b1;
            step_d  = 3'd0;
            a0_d    = 1'b0;
            dout_d  = icw1 | 8'h10;
            state_d = S_SETUP;
          end
          act_q: begin
            if (step_nx == 3'd5) begin
              act_d  = 1'b0;
              done_d = 1'b1;
            end else begin
              step_d  = step_nx;
              a0_d    = 1'b1;
              dout_d  = nx_word;
              state_d = S_SETUP;
            end
          end
          ack_go: begin
            cnt_d   = '0;
            state_d = S_INTA1;
          end
          (cmd_valid && cmd_ready): begin
            a0_d    = cmd_a0;
            dout_d  = cmd_data;
            state_d = S_SETUP;
          end
          default: ;
        endcase
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (cnt_q == WR_LAST) state_d = S_HOLD;
        else cnt_d = cnt_q + 8'd1;
      end
      S_HOLD: state_d = S_IDLE;
      S_INTA1: begin
        if (cnt_q == IA_LAST) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_INTA2;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_INTA2: begin
        if (cnt_q == IA_LAST) begin
          vec_d   = data_in;
          state_d = S_VEC;
        end else cnt_d = cnt_q + 8'd1;
      end
      S_VEC:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      a0_q    <= 1'b0;
      dout_q  <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      act_q   <= act_d;
      done_q  <= done_d;
      a0_q    <= a0_d;
      dout_q  <= dout_d;
      vec_q   <= vec_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w1_q <= '0;
      w2_q <= '0;
      w3_q <= '0;
      w4_q <= '0;
      wm_q <= '0;
    end else if (state_q == S_IDLE && init_start) begin
      w1_q <= icw1;
      w2_q <= icw2;
      w3_q <= icw3;
      w4_q <= icw4;
      wm_q <= init_mask;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pic_int;
      sync2_q <= sync1_q;
    end
  end

  // Strobes are registered from the next state so the pins stay glitch-free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      inta_n_q <= 1'b1;
      vv_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      cs_n_q   <= !(state_d == S_SETUP || state_d == S_STROBE
                    || state_d == S_HOLD);
      oe_q     <= state_d == S_SETUP || state_d == S_STROBE
                  || state_d == S_HOLD;
      wr_n_q   <= state_d != S_STROBE;
      inta_n_q <= !(state_d == S_INTA1 || state_d == S_INTA2);
      vv_q     <= state_d == S_VEC;
      busy_q   <= state_d != S_IDLE;
    end
  end

  assign cs_n      = cs_n_q;
  assign wr_n      = wr_n_q;
  assign data_oe   = oe_q;
  assign a0        = a0_q;
  assign data_out  = dout_q;
  assign inta_n    = inta_n_q;
  assign vec_valid = vv_q;
  assign vec_data  = vec_q;
  assign init_done = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb_pic_host_sequencer: directed bench for the PIC host sequencer.
// Init sequences, OCW write, INTA cycle, priorities and async reset.
module tb_pic_host_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       init_start;
  logic [7:0] icw1, icw2, icw3, icw4, init_mask;
  logic       cmd_valid, cmd_ready, cmd_a0;
  logic [7:0] cmd_data;
  logic       cs_n, wr_n, a0, data_oe;
  logic [7:0] data_out, data_in;
  logic       pic_int, inta_n, ack_en;
  logic       vec_valid, init_done, busy;
  logic [7:0] vec_data;

  pic_host_sequencer dut (
    .clk(clk), .reset_n(reset_n), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .init_mask(init_mask), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .data_out(data_out),
    .data_oe(data_oe), .data_in(data_in), .pic_int(pic_int),
    .inta_n(inta_n), .ack_en(ack_en), .vec_valid(vec_valid),
    .vec_data(vec_data), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] wlog[$];
  int         wlen[$];
  int         lowcnt     = 0;
  logic       last_wr    = 1'b1;
  int         bad_strobe = 0;
  int         inta_lows  = 0;

  // Bus observer: logs each write's {a0,data} and its wr_n low width.
  always @(negedge clk) begin
    if (!wr_n && last_wr) wlog.push_back({a0, data_out});
    if (!wr_n && (cs_n || !data_oe)) bad_strobe++;
    if (!wr_n) lowcnt++;
    else if (lowcnt != 0) begin
      wlen.push_back(lowcnt);
      lowcnt = 0;
    end
    if (!inta_n) inta_lows++;
    last_wr = wr_n;
  end

  task automatic chk1(input string tag, input logic o, input logic e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, o, e);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] o,
                      input logic [7:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chki(input string tag, input int o, input int e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic chkw(input string tag, input int idx,
                      input logic [8:0] e);
    logic [8:0] v;
    v = 9'h1FF;
    if (idx < wlog.size()) v = wlog[idx];
    n_chk++;
    assert (v === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, v, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    wlog.delete();
    wlen.delete();
  endtask

  task automatic do_init(input logic [7:0] w1, input logic [7:0] w2,
                         input logic [7:0] w3, input logic [7:0] w4,
                         input logic [7:0] wm, output int cyc);
    clr_log();
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; init_mask = wm;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    icw1 = 8'hEE; icw2 = 8'hEE; icw3 = 8'hEE;
    icw4 = 8'hEE; init_mask = 8'hEE;
    cyc = 0;
    while (!init_done && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk1(tag, busy, 1'b0);
  endtask

  task automatic wait_vec(input string tag, input logic [7:0] e);
    int n;
    n = 0;
    while (!vec_valid && n < 60) begin
      step();
      n++;
      if (!inta_n) pic_int = 1'b0;
    end
    chk1({tag, "_vv"}, vec_valid, 1'b1);
    chk8({tag, "_vec"}, vec_data, e);
  endtask

  initial begin
    int       cyc;
    int       seen;
    logic [9:1] inta_exp;

    reset_n = 1'b0; init_start = 1'b0;
    icw1 = '0; icw2 = '0; icw3 = '0; icw4 = '0; init_mask = '0;
    cmd_valid = 1'b0; cmd_a0 = 1'b0; cmd_data = '0;
    data_in = '0; pic_int = 1'b0; ack_en = 1'b1;
    step();
    step();
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_wr_n", wr_n, 1'b1);
    chk1("rst_inta_n", inta_n, 1'b1);
    chk1("rst_a0", a0, 1'b0);
    chk8("rst_dout", data_out, 8'h00);
    chk1("rst_oe", data_oe, 1'b0);
    chk1("rst_ready", cmd_ready, 1'b0);
    chk1("rst_vv", vec_valid, 1'b0);
    chk8("rst_vec", vec_data, 8'h00);
    chk1("rst_done", init_done, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    #3 reset_n = 1'b1;
    step();

    // single mode with ICW4
    do_init(8'h13, 8'h20, 8'hAA, 8'h01, 8'hFB, cyc);
    chki("t1_cycles", cyc, 20);
    chki("t1_nwr", wlog.size(), 4);
    chkw("t1_w0", 0, 9'h013);
    chkw("t1_w1", 1, 9'h120);
    chkw("t1_w2", 2, 9'h101);
    chkw("t1_w3", 3, 9'h1FB);
    for (int i = 0; i < 4; i++)
      chki("t1_len", (i < wlen.size()) ? wlen[i] : -1, 2);

    // cascade, no ICW4
    do_init(8'h10, 8'h08, 8'h04, 8'h55, 8'hFF, cyc);
    chki("t2_cycles", cyc, 20);
    chki("t2_nwr", wlog.size(), 4);
    chkw("t2_w0", 0, 9'h010);
    chkw("t2_w1", 1, 9'h108);
    chkw("t2_w2", 2, 9'h104);
    chkw("t2_w3", 3, 9'h1FF);

    // OCW2 single write
    step();
    clr_log();
    cmd_a0 = 1'b0; cmd_data = 8'h20; cmd_valid = 1'b1;
    #1;
    chk1("ocw_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0; cmd_data = 8'h00;
    chk1("ocw_su_cs", cs_n, 1'b0);
    chk1("ocw_su_wr", wr_n, 1'b1);
    chk1("ocw_su_oe", data_oe, 1'b1);
    chk1("ocw_su_a0", a0, 1'b0);
    chk8("ocw_su_d", data_out, 8'h20);
    chk1("ocw_su_rdy", cmd_ready, 1'b0);
    chk1("ocw_su_busy", busy, 1'b1);
    step();
    chk1("ocw_st1_wr", wr_n, 1'b0);
    chk1("ocw_st1_rdy", cmd_ready, 1'b0);
    step();
    chk1("ocw_st2_wr", wr_n, 1'b0);
    chk1("ocw_st2_rdy", cmd_ready, 1'b0);
    step();
    chk1("ocw_ho_wr", wr_n, 1'b1);
    chk1("ocw_ho_cs", cs_n, 1'b0);
    chk1("ocw_ho_oe", data_oe, 1'b1);
    chk1("ocw_ho_rdy", cmd_ready, 1'b0);
    step();
    chk1("ocw_end_cs", cs_n, 1'b1);
    chk1("ocw_end_oe", data_oe, 1'b0);
    chk1("ocw_end_busy", busy, 1'b0);
    chk1("ocw_end_rdy", cmd_ready, 1'b1);
    chki("ocw_nwr", wlog.size(), 1);
    chkw("ocw_w0", 0, 9'h020);
    chki("ocw_len", (wlen.size() > 0) ? wlen[0] : -1, 2);

    // acknowledge: 3-cycle latency, low 2 / high 1 / low 2
    inta_exp = 9'b110010011;
    pic_int = 1'b1; data_in = 8'h99;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk1("ack_inta", inta_n, inta_exp[i]);
      chk1("ack_vv", vec_valid, i == 8);
      chk1("ack_busy", busy, i >= 3 && i <= 8);
      if (i == 8) chk8("ack_vec", vec_data, 8'h21);
      if (i == 3) pic_int = 1'b0;
      if (i == 7) data_in = 8'h21;
      if (i == 8) data_in = 8'h99;
    end
    chk1("ack_rdy", cmd_ready, 1'b1);

    // ack_en gates the start only
    ack_en = 1'b0; pic_int = 1'b1; data_in = 8'h5C;
    inta_lows = 0;
    for (int i = 0; i < 6; i++) step();
    chki("gate_inta", inta_lows, 0);
    chk1("gate_rdy", cmd_ready, 1'b1);
    ack_en = 1'b1;
    wait_vec("gate", 8'h5C);
    wait_idle("gate_idle");

    // ack wins over a pending command
    step();
    clr_log();
    cmd_a0 = 1'b1; cmd_data = 8'hF0; cmd_valid = 1'b1;
    step();
    cmd_a0 = 1'b0; cmd_data = 8'h0B;
    pic_int = 1'b1; data_in = 8'h47;
    wait_vec("sim", 8'h47);
    chki("sim_nwr_at_vec", wlog.size(), 1);
    seen = 0;
    while (!cmd_ready && seen < 20) begin
      step();
      seen++;
    end
    chk1("sim_rdy", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    wait_idle("sim_idle");
    chki("sim_nwr", wlog.size(), 2);
    chkw("sim_w0", 0, 9'h1F0);
    chkw("sim_w1", 1, 9'h00B);

    // init wins over a raised INT
    step();
    step();
    inta_lows = 0;
    pic_int = 1'b1; data_in = 8'h33;
    do_init(8'h13, 8'h20, 8'hAA, 8'h01, 8'hFB, cyc);
    chki("ini_cycles", cyc, 20);
    chki("ini_inta", inta_lows, 0);
    chki("ini_nwr", wlog.size(), 4);
    wait_vec("ini", 8'h33);
    wait_idle("ini_idle");

    // async reset in the middle of the strobe
    step();
    step();
    cmd_a0 = 1'b1; cmd_data = 8'h77; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    chk1("rs_pre_wr", wr_n, 1'b0);
    chk1("rs_pre_cs", cs_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk1("rs_wr", wr_n, 1'b1);
    chk1("rs_cs", cs_n, 1'b1);
    chk1("rs_oe", data_oe, 1'b0);
    chk1("rs_done", init_done, 1'b0);
    chk1("rs_busy", busy, 1'b0);
    #3 reset_n = 1'b1;
    clr_log();
    cmd_a0 = 1'b1; cmd_data = 8'h66; cmd_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cmd_ready) seen++;
    end
    chki("rs_rdy_seen", seen, 0);
    chki("rs_nwr", wlog.size(), 0);
    cmd_valid = 1'b0;
    do_init(8'h03, 8'h11, 8'h22, 8'h33, 8'h44, cyc);
    chki("rs_cycles", cyc, 20);
    chkw("rs_w0", 0, 9'h013);
    chkw("rs_w1", 1, 9'h111);
    chkw("rs_w2", 2, 9'h133);
    chkw("rs_w3", 3, 9'h144);
    step();
    cmd_valid = 1'b1;
    #1;
    chk1("rs_rdy", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
    wait_idle("rs_idle");
    chkw("rs_w4", 4, 9'h166);
    chki("strobe_cs", bad_strobe, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
